// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response plus redirect and decoder handshake.
// master = fetch_unit; slave = surrounding memory, jump logic and decoder.
interface fetch_unit_if #(
    parameter int ADDR_SIZE  = 16,
    parameter int INSTR_SIZE = 32
);
    logic                  mem_req;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [INSTR_SIZE-1:0] mem_rdata;
    logic                  redirect;
    logic [ADDR_SIZE-1:0]  redirect_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic [INSTR_SIZE-1:0] out_instr;
    logic [ADDR_SIZE-1:0]  out_ip;

    modport master (
        output mem_req, mem_addr, out_valid, out_instr, out_ip,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_addr, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_instr, out_ip,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_addr, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch, one outstanding read, DEPTH-entry prefetch FIFO; gnt->out_valid 2 cycles.
// A stalled decoder fills the FIFO and then holds mem_req low; redirect flushes the FIFO and drops any in-flight read.
module fetch_unit #(
    parameter int                   ADDR_SIZE  = 16,
    parameter int                   INSTR_SIZE = 32,
    parameter int                   DEPTH      = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_ADDR = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_SIZE-1:0]  ip;
        logic [INSTR_SIZE-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t               state;
    entry_t               fifo_mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [ADDR_SIZE-1:0] fetch_ptr;
    logic [ADDR_SIZE-1:0] req_addr;

    logic granted;
    logic push;
    logic pop;

    assign bus.mem_req   = (state == IDLE) && (count < CW'(DEPTH)) && !rst;
    assign bus.mem_addr  = fetch_ptr;
    assign bus.out_valid = !rst && (count != '0) && !bus.redirect;
    assign bus.out_instr = fifo_mem[rd_ptr].instr;
    assign bus.out_ip    = fifo_mem[rd_ptr].ip;

    assign granted = bus.mem_req && bus.mem_gnt;
    // A response coinciding with a redirect belongs to the abandoned stream.
    assign push    = (state == WAIT) && bus.mem_rvalid && !bus.redirect;
    assign pop     = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{ip: req_addr, instr: bus.mem_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_ptr <= RESET_ADDR;
            req_addr  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (bus.redirect) begin
                fetch_ptr <= bus.redirect_addr;
                rd_ptr    <= wr_ptr;
                count     <= '0;
            end else begin
                if (granted) fetch_ptr <= fetch_ptr + 1'b1;
                if (push)    wr_ptr    <= wr_ptr + 1'b1;
                if (pop)     rd_ptr    <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end

            if (granted) req_addr <= fetch_ptr;

            case (state)
                IDLE: if (granted) state <= bus.redirect ? DROP : WAIT;
                WAIT: begin
                    if (bus.mem_rvalid)        state <= IDLE;
                    else if (bus.redirect)     state <= DROP;
                end
                DROP: if (bus.mem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios then randomized traffic against a queue-based model of the fetch stream.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    fetch_unit_if #(.ADDR_SIZE(16), .INSTR_SIZE(32)) bus ();

    fetch_unit #(
        .ADDR_SIZE(16), .INSTR_SIZE(32), .DEPTH(DEPTH), .RESET_ADDR(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ip;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [15:0] pops[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc, grants, first_gnt, first_valid;
    int          gnt_min, gnt_max, rv_min, rv_max;
    int          gnt_wait, rv_wait;
    logic        outst, pend_live;
    logic [15:0] pend_addr, pend_exp, exp_fp;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after negedge, act as memory, check outputs, advance the model.
    task automatic tick(input logic r, input logic rd, input logic [15:0] ra, input logic rdy);
        logic g, rv, exp_valid, exp_req;
        @(negedge clk);
        rst = r;
        bus.redirect = rd;
        bus.redirect_addr = ra;
        bus.out_ready = rdy;
        #1;
        g = 1'b0;
        rv = 1'b0;
        if (!r && bus.mem_req) begin
            if (gnt_wait < 0) gnt_wait = $urandom_range(gnt_max, gnt_min);
            if (gnt_wait == 0) begin
                g = 1'b1;
                gnt_wait = -1;
            end else gnt_wait--;
        end else gnt_wait = -1;
        if (!r && outst) begin
            if (rv_wait == 0) rv = 1'b1;
            else rv_wait--;
        end
        bus.mem_gnt = g;
        bus.mem_rvalid = rv;
        bus.mem_rdata = rv ? mem_word(pend_addr) : $urandom();
        #1;
        exp_valid = !r && (q.size() != 0) && !rd;
        exp_req   = !r && !outst && (q.size() < DEPTH);
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("mem_req", 64'(bus.mem_req), 64'(exp_req));
        if (exp_req) chk("mem_addr", 64'(bus.mem_addr), 64'(exp_fp));
        if (exp_valid && bus.out_valid) begin
            chk("out_ip", 64'(bus.out_ip), 64'(q[0].ip));
            chk("out_instr", 64'(bus.out_instr), 64'(q[0].instr));
        end
        if (r) begin
            q.delete();
            outst = 1'b0;
            pend_live = 1'b0;
            exp_fp = 16'h0000;
            gnt_wait = -1;
        end else begin
            if (exp_valid && rdy) begin
                pops.push_back(q[0].ip);
                void'(q.pop_front());
            end
            if (rd) q.delete();
            if (rv) begin
                outst = 1'b0;
                if (pend_live && !rd) q.push_back('{pend_exp, mem_word(pend_exp)});
            end
            if (g) begin
                outst = 1'b1;
                pend_addr = bus.mem_addr;
                pend_exp = exp_fp;
                pend_live = !rd;
                rv_wait = $urandom_range(rv_max, rv_min);
                grants++;
                if (first_gnt < 0) first_gnt = cyc;
                if (!rd) exp_fp = exp_fp + 16'h1;
            end
            if (rd) begin
                exp_fp = ra;
                pend_live = 1'b0;
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
        end
        cyc++;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        cyc = 0;
        grants = 0;
        first_gnt = -1;
        first_valid = -1;
        pops.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_addr = '0;
        bus.out_ready = 1'b0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        outst = 1'b0;
        pend_live = 1'b0;
        pend_addr = '0;
        pend_exp = '0;
        exp_fp = '0;
        gnt_wait = -1;
        rv_wait = 0;
        gnt_min = 0; gnt_max = 0; rv_min = 0; rv_max = 0;

        // Fast memory, decoder always ready: ips 0..3, first output two cycles after first grant.
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 40 && pops.size() < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t1_pops", 64'(pops.size()), 64'd4);
        for (int i = 0; i < pops.size() && i < 4; i++) chk("t1_ip_seq", 64'(pops[i]), 64'(i));
        chk("t1_first_gnt", 64'(first_gnt), 64'd0);
        chk("t1_first_valid", 64'(first_valid), 64'd2);

        // Stalled decoder: FIFO fills with exactly DEPTH words, then one pop frees one request at 4.
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t2_grants", 64'(grants), 64'(DEPTH));
        chk("t2_req_stalled", 64'(bus.mem_req), 64'd0);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t2_one_pop", 64'(pops.size()), 64'd1);
        tick(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t2_req_after_pop", 64'(bus.mem_req), 64'd1);
        chk("t2_addr_after_pop", 64'(bus.mem_addr), 64'h4);

        // Redirect while waiting; stale response lands three cycles after the grant.
        do_reset();
        rv_min = 2; rv_max = 2;
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b1, 16'h0100, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_req", 64'(bus.mem_req), 64'd1);
        chk("t3_addr", 64'(bus.mem_addr), 64'h0100);
        rv_min = 0; rv_max = 0;
        pops.delete();
        for (int i = 0; i < 30 && pops.size() < 1; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_pops", 64'(pops.size()), 64'd1);
        if (pops.size() > 0) chk("t3_first_ip", 64'(pops[0]), 64'h0100);

        // Redirect in the same cycle as the response.
        do_reset();
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        tick(1'b0, 1'b1, 16'h0100, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t4_dropped", 64'(bus.out_valid), 64'd0);
        chk("t4_req", 64'(bus.mem_req), 64'd1);
        chk("t4_addr", 64'(bus.mem_addr), 64'h0100);

        // Redirect in IDLE without grant restarts next cycle; address wraps 0xFFFF -> 0x0000.
        do_reset();
        gnt_min = 3; gnt_max = 3;
        tick(1'b0, 1'b1, 16'hFFFF, 1'b1);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t5_req", 64'(bus.mem_req), 64'd1);
        chk("t5_addr", 64'(bus.mem_addr), 64'hFFFF);
        gnt_min = 0; gnt_max = 0;
        pops.delete();
        for (int i = 0; i < 40 && pops.size() < 2; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t5_pops", 64'(pops.size()), 64'd2);
        if (pops.size() >= 2) begin
            chk("t5_ip0", 64'(pops[0]), 64'hFFFF);
            chk("t5_ip1", 64'(pops[1]), 64'h0000);
        end

        // Random delays, random decoder stalls, random redirects and the occasional reset.
        do_reset();
        gnt_min = 0; gnt_max = 5; rv_min = 0; rv_max = 5;
        for (int i = 0; i < 3000; i++) begin
            logic r, rd, rdy;
            logic [15:0] ra;
            r   = ($urandom_range(499) == 0);
            rd  = ($urandom_range(99) < 3);
            ra  = ($urandom_range(3) == 0) ? 16'(16'hFFFE + $urandom_range(2)) : 16'($urandom());
            rdy = ($urandom_range(99) < 65);
            tick(r, rd, ra, rdy);
        end
        chk("t6_progress", 64'(pops.size() > 100), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
